divider_ctrl: RTL and testbench

//   Runtime controller for one divider instance, clocked from the 100MHz clk_in.

---
 rtl/divider_ctrl_if.sv | 8 +
 rtl/divider_ctrl.sv | 98 +++++++++
 tb/tb_divider_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/divider_ctrl_if.sv
// divider_ctrl_if: valid/ready handshake carrying division-factor change requests
interface divider_ctrl_if #(parameter int WIDTH = 32);
   logic             req_valid;
   logic [WIDTH-1:0] req_factor;
   logic             req_ready;
   modport master (output req_valid, req_factor, input req_ready);
   modport slave  (input req_valid, req_factor, output req_ready);
endinterface

// File: rtl/divider_ctrl.sv
// divider_ctrl: range-checks factor requests and applies them at a divider low phase,
// holding the divider in reset for a fixed window so no runt or stretched pulse escapes
module divider_ctrl #(
   parameter int WIDTH          = 32,
   parameter int DEFAULT_FACTOR = 1000,
   parameter int MIN_FACTOR     = 2,
   parameter int MAX_FACTOR     = 100000000,
   parameter int HOLD_CYCLES    = 4
) (
   input  logic              clk_in,
   input  logic              rst_,
   divider_ctrl_if.slave     req,
   input  logic              div_clk,
   output logic [WIDTH-1:0]  div_factor,
   output logic              div_rst_,
   output logic              busy,
   output logic              applied,
   output logic              err,
   output logic              timeout
);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   typedef enum logic [1:0] {INIT, IDLE, WAIT_EDGE, HOLD} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] div_factor_q, pending_q;
   logic [WIDTH:0]   tmo_cnt_q;
   logic [HW-1:0]    hold_cnt_q;
   logic             div_clk_q, div_rst_q, req_ready_q, busy_q, applied_q, err_q, timeout_q;
   logic             fall, accept, in_range, hold_done, tmo_hit;
   assign fall      = div_clk_q & ~div_clk;
   assign accept    = req.req_valid & req_ready_q;
   assign in_range  = req.req_factor >= WIDTH'(MIN_FACTOR) && req.req_factor <= WIDTH'(MAX_FACTOR);
   assign hold_done = hold_cnt_q == HW'(HOLD_CYCLES - 1);
   // one extra bit so a factor at the top of the range cannot wrap the wait counter
   assign tmo_hit   = tmo_cnt_q == {1'b0, div_factor_q};
   assign req.req_ready = req_ready_q;
   assign div_factor    = div_factor_q;
   assign div_rst_      = div_rst_q;
   assign busy          = busy_q;
   assign applied       = applied_q;
   assign err           = err_q;
   assign timeout       = timeout_q;
   always_ff @(posedge clk_in or negedge rst_) begin
      if (!rst_) begin
         state_q      <= INIT;
         div_factor_q <= WIDTH'(DEFAULT_FACTOR);
         pending_q    <= '0;
         tmo_cnt_q    <= '0;
         hold_cnt_q   <= '0;
         div_clk_q    <= 1'b0;
         div_rst_q    <= 1'b0;
         req_ready_q  <= 1'b0;
         busy_q       <= 1'b1;
         applied_q    <= 1'b0;
         err_q        <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         div_clk_q <= div_clk;
         applied_q <= 1'b0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            INIT, HOLD: begin
               if (hold_done) begin
                  state_q     <= IDLE;
                  hold_cnt_q  <= '0;
                  div_rst_q   <= 1'b1;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  applied_q   <= state_q == HOLD;
               end else hold_cnt_q <= hold_cnt_q + 1'b1;
            end
            IDLE: begin
               if (accept) begin
                  if (!in_range) err_q <= 1'b1;
                  else if (req.req_factor == div_factor_q) applied_q <= 1'b1;
                  else begin
                     pending_q   <= req.req_factor;
                     tmo_cnt_q   <= '0;
                     state_q     <= WAIT_EDGE;
                     req_ready_q <= 1'b0;
                     busy_q      <= 1'b1;
                  end
               end
            end
            WAIT_EDGE: begin
               if (fall || tmo_hit) begin
                  timeout_q    <= ~fall;
                  state_q      <= HOLD;
                  div_rst_q    <= 1'b0;
                  div_factor_q <= pending_q;
                  hold_cnt_q   <= '0;
               end else tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            default: state_q <= INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_divider_ctrl.sv
// tb_divider_ctrl: directed checks of reset, range errors, no-op apply, timeout,
// edge-aligned apply with a model divider attached, and reset mid-operation
module tb_divider_ctrl;
   localparam int W = 32;
   logic          clk_in = 1'b0;
   logic          rst_ = 1'b1;
   logic          use_div = 1'b0;
   logic          div_clk, dout;
   logic [W-1:0]  div_factor, dcnt;
   logic          div_rst_, busy, applied, err, timeout;
   int            n_checks = 0;
   int            n_fail = 0;
   divider_ctrl_if #(.WIDTH(W)) req ();
   divider_ctrl dut (
      .clk_in(clk_in), .rst_(rst_), .req(req), .div_clk(div_clk),
      .div_factor(div_factor), .div_rst_(div_rst_), .busy(busy),
      .applied(applied), .err(err), .timeout(timeout)
   );
   always #5 clk_in = ~clk_in;
   // model divider: low for factor/2 cycles, then high, period = factor
   always @(posedge clk_in) dcnt <= (!div_rst_ || dcnt == div_factor - 1) ? '0 : dcnt + 1;
   assign dout    = dcnt >= div_factor / 2;
   assign div_clk = use_div & dout;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk_in);
   endtask
   task automatic send(input logic [W-1:0] f);
      req.req_valid = 1'b1;
      req.req_factor = f;
      tick(1);
      req.req_valid = 1'b0;
   endtask
   task automatic wait_timeout(output int n);
      n = 0;
      while (!timeout && n < 3000) begin tick(1); n++; end
   endtask
   task automatic wait_applied(output int n);
      n = 0;
      while (!applied && n < 3000) begin tick(1); n++; end
   endtask
   task automatic run_len(input logic v, output int n);
      n = 0;
      while (div_clk === v && n < 3000) begin n++; tick(1); end
   endtask
   initial begin
      int   n, fall_k, rst_k, app_k, low, a, b, c;
      logic prev;
      req.req_valid = 1'b0;
      req.req_factor = '0;
      #1 rst_ = 1'b0;
      tick(2);
      check("rst_factor", div_factor, 1000);
      check("rst_div_rst", div_rst_, 0);
      check("rst_ready", req.req_ready, 0);
      check("rst_busy", busy, 1);
      check("rst_pulses", {applied, err, timeout}, 0);
      tick(48);
      rst_ = 1'b1;
      tick(3);
      check("init_div_rst", div_rst_, 0);
      check("init_ready", req.req_ready, 0);
      tick(1);
      check("idle_div_rst", div_rst_, 1);
      check("idle_ready", req.req_ready, 1);
      check("idle_busy", busy, 0);
      // out-of-range requests
      send(1);
      check("err_lo", err, 1);
      check("err_lo_applied", applied, 0);
      check("err_lo_factor", div_factor, 1000);
      check("err_lo_div_rst", div_rst_, 1);
      tick(1);
      check("err_pulse_end", err, 0);
      send(100000001);
      check("err_hi", err, 1);
      check("err_hi_factor", div_factor, 1000);
      check("err_hi_ready", req.req_ready, 1);
      tick(1);
      send(0);
      check("err_zero", err, 1);
      tick(1);
      // request equal to current factor
      send(1000);
      check("same_applied", applied, 1);
      check("same_busy", busy, 0);
      check("same_div_rst", div_rst_, 1);
      check("same_err", err, 0);
      tick(1);
      check("same_pulse_end", applied, 0);
      // divider stuck low -> timeout after factor+1 cycles
      send(2000);
      check("tmo_busy", busy, 1);
      check("tmo_ready", req.req_ready, 0);
      wait_timeout(n);
      check("tmo_latency", n, 1001);
      check("tmo_div_rst", div_rst_, 0);
      check("tmo_factor", div_factor, 2000);
      check("tmo_applied", applied, 0);
      tick(1);
      check("tmo_pulse_end", timeout, 0);
      tick(2);
      check("tmo_hold", div_rst_, 0);
      tick(1);
      check("tmo_applied_end", applied, 1);
      check("tmo_release", div_rst_, 1);
      check("tmo_ready_back", req.req_ready, 1);
      // divider attached: apply must follow a falling edge
      use_div = 1'b1;
      tick(3);
      prev = div_clk;
      send(500);
      check("edge_busy", busy, 1);
      fall_k = -1; rst_k = -1; app_k = -1; low = 0;
      for (int k = 0; k < 3000; k++) begin
         if (fall_k < 0 && prev && !div_clk) fall_k = k;
         if (!div_rst_) low++;
         if (rst_k < 0 && !div_rst_) rst_k = k;
         if (applied) begin app_k = k; break; end
         prev = div_clk;
         tick(1);
      end
      check("edge_rst_after_fall", rst_k, fall_k + 1);
      check("edge_hold_len", low, 4);
      check("edge_applied_at", app_k, rst_k + 4);
      check("edge_factor", div_factor, 500);
      check("edge_timeout", timeout, 0);
      run_len(0, a);
      run_len(1, b);
      run_len(0, c);
      check("clk_first_low", a, 250);
      check("clk_high", b, 250);
      check("clk_period", b + c, 500);
      // reset asserted during HOLD
      use_div = 1'b0;
      send(700);
      wait_timeout(n);
      check("rst6_tmo_latency", n, 501);
      #2 rst_ = 1'b0;
      #1;
      check("rst6_factor", div_factor, 1000);
      check("rst6_div_rst", div_rst_, 0);
      check("rst6_busy", busy, 1);
      check("rst6_timeout", timeout, 0);
      tick(2);
      rst_ = 1'b1;
      tick(4);
      check("rst6_ready", req.req_ready, 1);
      check("rst6_factor_idle", div_factor, 1000);
      // request raised while busy waits until IDLE returns
      send(700);
      req.req_valid = 1'b1;
      req.req_factor = 900;
      wait_applied(n);
      check("held_first_factor", div_factor, 700);
      check("held_ready", req.req_ready, 1);
      tick(1);
      req.req_valid = 1'b0;
      check("held_accepted", busy, 1);
      wait_applied(n);
      check("held_applied", applied, 1);
      check("held_factor", div_factor, 900);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
